// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  // Arbitration FSM: free round-robin, or port 1 holding a locked burst.
  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } state_t;

  // Requester indices into the grant vector.
  localparam int unsigned P_PIPE    = 0;
  localparam int unsigned P_LOAD    = 1;
  localparam int unsigned NUM_PORTS = 2;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port not granted last.
module dmem_arbiter_rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_gnt,
  output logic [NUM_PORTS-1:0] gnt_c
);

  // Tie-break against the previous winner, otherwise pass the request through.
  always_comb begin
    gnt_c = '0;
    if (req[P_PIPE] && req[P_LOAD]) begin
      gnt_c = last_gnt ? 2'b01 : 2'b10;
    end else begin
      gnt_c = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported data memory between the pipeline MEM stage (port 0)
// and the loader/debug port (port 1), with locked bursts and starvation relief.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              err0,
  output logic              err1,
  output logic              stall_mem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  state_t                 state;
  logic                   last_gnt;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [NUM_PORTS-1:0]   rr_gnt_c;
  logic [NUM_PORTS-1:0]   gnt_vec_c;
  logic                   force0_c;
  logic                   any_gnt_c;
  logic                   sel_load_c;
  logic [ADDR_W-1:0]      sel_addr_c;
  logic [DATA_W-1:0]      sel_wdata_c;
  logic                   sel_we_c;
  logic                   misalign_c;

  dmem_arbiter_rr_arb2 u_rr (
    .req      ({req1, req0}),
    .last_gnt (last_gnt),
    .gnt_c    (rr_gnt_c)
  );

  // Grant selection: starving port 0 first, then an active lock, else round robin.
  always_comb begin
    force0_c  = req0 && (wait_cnt == WAIT_W'(MAX_WAIT));
    gnt_vec_c = '0;
    if (!rst_n) begin
      gnt_vec_c = '0;
    end else if (force0_c) begin
      gnt_vec_c = 2'b01;
    end else if ((state == LOCK1) && req1 && lock1) begin
      gnt_vec_c = 2'b10;
    end else begin
      gnt_vec_c = rr_gnt_c;
    end
  end

  assign gnt0      = gnt_vec_c[P_PIPE];
  assign gnt1      = gnt_vec_c[P_LOAD];
  assign stall_mem = req0 && !gnt0;

  // Request mux toward the memory; misaligned accesses are granted but never reach it.
  always_comb begin
    any_gnt_c   = |gnt_vec_c;
    sel_load_c  = gnt_vec_c[P_LOAD];
    sel_addr_c  = sel_load_c ? addr1  : addr0;
    sel_wdata_c = sel_load_c ? wdata1 : wdata0;
    sel_we_c    = sel_load_c ? we1    : we0;
    misalign_c  = |sel_addr_c[1:0];
    mem_addr    = any_gnt_c ? sel_addr_c  : '0;
    mem_wdata   = any_gnt_c ? sel_wdata_c : '0;
    mem_we      = any_gnt_c && sel_we_c  && !misalign_c;
    mem_re      = any_gnt_c && !sel_we_c && !misalign_c;
  end

  // FSM, fairness state, starvation counter and the registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARB;
      last_gnt <= 1'b1;
      wait_cnt <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata    <= '0;
    end else begin
      state <= (gnt1 && lock1) ? LOCK1 : ARB;
      if (any_gnt_c) begin
        last_gnt <= sel_load_c;
      end
      if (!req0 || gnt0) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      err0    <= gnt0 && misalign_c;
      err1    <= gnt1 && misalign_c;
      if (any_gnt_c && misalign_c) begin
        rdata <= '0;
      end else if (any_gnt_c && !sel_we_c) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a response scoreboard and a small DMEM model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1, lock1;
  logic [6:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, stall_mem;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [6:0]  mem_addr;
  logic        mem_we, mem_re;

  typedef struct {
    logic        rv0;
    logic        rv1;
    logic        er0;
    logic        er1;
    logic [31:0] rd;
  } resp_t;

  resp_t       sbq[$];
  logic [31:0] ref_mem [32];
  logic [31:0] exp_rdata;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] dmem [32];
  logic        filled = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .lock1     (lock1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .err0      (err0),
    .err1      (err1),
    .stall_mem (stall_mem),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  // DMEM model: filled with a known pattern on the first edge, then written on mem_we.
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 32; i++) dmem[i] <= 32'h5000_0000 + 32'(i) * 32'h0101;
      filled <= 1'b1;
    end else if (mem_we) begin
      dmem[mem_addr[6:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = dmem[mem_addr[6:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One arbitrated cycle: check grants/memory controls, queue the response, check it after the edge.
  task automatic step(input logic e0, input logic e1);
    logic       g;
    logic [6:0] a;
    logic       w;
    logic       mis;
    resp_t      r;
    #3;
    g   = e0 | e1;
    a   = e1 ? addr1 : addr0;
    w   = e1 ? we1 : we0;
    mis = (a[1:0] != 2'b00);
    chk("gnt0", 32'(gnt0), 32'(e0));
    chk("gnt1", 32'(gnt1), 32'(e1));
    chk("stall_mem", 32'(stall_mem), 32'(req0 & ~e0));
    chk("mem_re", 32'(mem_re), 32'(g & ~w & ~mis));
    chk("mem_we", 32'(mem_we), 32'(g & w & ~mis));
    chk("mem_addr", 32'(mem_addr), g ? 32'(a) : 32'h0);
    r.rv0 = e0;
    r.rv1 = e1;
    r.er0 = e0 & mis;
    r.er1 = e1 & mis;
    if (g && mis) exp_rdata = 32'h0;
    else if (g && !w) exp_rdata = ref_mem[a[6:2]];
    r.rd = exp_rdata;
    if (g && w && !mis) ref_mem[a[6:2]] = e1 ? wdata1 : wdata0;
    sbq.push_back(r);
    @(posedge clk);
    #1;
    r = sbq.pop_front();
    chk("rvalid0", 32'(rvalid0), 32'(r.rv0));
    chk("rvalid1", 32'(rvalid1), 32'(r.rv1));
    chk("err0", 32'(err0), 32'(r.er0));
    chk("err1", 32'(err1), 32'(r.er1));
    chk("rdata", rdata, r.rd);
  endtask

  // One cycle with reset held: all pending responses are dropped.
  task automatic rst_cycle(input string tag);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sbq.delete();
    exp_rdata = 32'h0;
    chk({tag, "_rvalid0"}, 32'(rvalid0), 32'h0);
    chk({tag, "_rvalid1"}, 32'(rvalid1), 32'h0);
    chk({tag, "_err"}, 32'({err0, err1}), 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h5000_0000 + 32'(i) * 32'h0101;
    exp_rdata = 32'h0;
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h04; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 7'h00; wdata1 = 32'h0;
    lock1 = 1'b0;

    // Reset held two cycles with a pending port-0 request.
    rst_cycle("reset0");
    rst_cycle("reset1");
    rst_n = 1'b1;

    // First port-0 read after reset.
    step(1'b1, 1'b0);

    // Port-0 write then read-back.
    we0 = 1'b1; addr0 = 7'h08; wdata0 = 32'hDEAD_BEEF;
    step(1'b1, 1'b0);
    we0 = 1'b0;
    step(1'b1, 1'b0);
    chk("readback", rdata, 32'hDEAD_BEEF);

    // Lone port-1 write so port 1 was the last winner.
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h10; wdata1 = 32'h1234_5678;
    step(1'b0, 1'b1);

    // Both requesting, no lock: strict alternation starting with port 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h10;
    we1 = 1'b0; addr1 = 7'h0C;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);

    // Locked port-1 burst; port 0 joins on the next cycle and is forced through after MAX_WAIT denials.
    req0 = 1'b0;
    lock1 = 1'b1; addr1 = 7'h08;
    step(1'b0, 1'b1);
    req0 = 1'b1; addr0 = 7'h04;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    req0 = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Reset in the middle of the locked read burst, then a tie must go to port 0.
    rst_cycle("rst_lock");
    rst_n = 1'b1;
    req0 = 1'b1; addr0 = 7'h04;
    step(1'b1, 1'b0);

    // Misaligned accesses: granted, memory untouched, error pulse with zero data.
    req1 = 1'b0; lock1 = 1'b0;
    addr0 = 7'h05;
    step(1'b1, 1'b0);
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h0A; wdata1 = 32'hFFFF_FFFF;
    step(1'b0, 1'b1);

    // Idle cycle: no grant, no response pulse, data held.
    req1 = 1'b0;
    step(1'b0, 1'b0);

    // The misaligned write must not have landed on word 2.
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h08;
    step(1'b1, 1'b0);
    chk("misaligned_write_dropped", rdata, 32'hDEAD_BEEF);
    req0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
